stream_demux16: RTL and testbench
=================================

// Module: stream_demux16
//
// PURPOSE
//   Registered 1:2 stream demultiplexer. It is the splitting counterpart of
//   the 16-bit 2:1 mux: one valid/ready input stream is steered to output
//   port A (sel=0) or port B (sel=1).
//   Each output has its own one-entry holding register, so a stalled port
//   never blocks traffic headed for the other port once that word is accepted.
//   It sits between a shared producer and two independent consumers on the
//   datapath.
//
// PARAMETERS
//   WIDTH   16   data width of in_data, a_data and b_data
//
// PORTS
//   clk       in   1      single clock, rising edge
//   rst_n     in   1      asynchronous, active-low reset
//   in_valid  in   1      producer has a word on in_data
//   in_ready  out  1      demux accepts the word this cycle
//   in_data   in   WIDTH  input word
//   sel       in   1      destination: 0 = port A, 1 = port B
//   a_valid   out  1      port A holding register full
//   a_ready   in   1      consumer A takes the word this cycle
//   a_data    out  WIDTH  port A word
//   b_valid   out  1      port B holding register full
//   b_ready   in   1      consumer B takes the word this cycle
//   b_data    out  WIDTH  port B word
//
// BEHAVIOUR
//   - Reset, asynchronous on rst_n=0: a_valid=b_valid=0, a_data=b_data=0.
//     With CNT_EN compiled in, a_count=b_count=0. Reset mid-transfer discards
//     held words immediately, without waiting for a clock edge.
//   - Per-port state: EMPTY (valid=0) or FULL (valid=1).
//   - in_ready, combinational:
//     sel=0 -> ~a_valid | a_ready;  sel=1 -> ~b_valid | b_ready.
//     No combinational path from in_valid to in_ready.
//   - Accept = in_valid & in_ready. sel and in_data are sampled only on
//     accept. The producer holds them stable while in_valid & ~in_ready.
//   - Latency: a word accepted at edge N is on the selected port's data/valid
//     after edge N. Throughput is 1 word/cycle to a port whose consumer keeps
//     ready high.
//   - Port transitions at each edge, per port X:
//       EMPTY, no load           -> EMPTY
//       EMPTY, load              -> FULL, X_data <= in_data
//       FULL,  X_ready, no load  -> EMPTY, X_data holds its last value
//       FULL,  X_ready, load     -> FULL, X_data <= new word (drain + refill)
//       FULL,  ~X_ready          -> FULL, X_data stable, no load possible
//   - The unselected port is unaffected by input activity. Its drain proceeds
//     independently in the same cycle.
//   - X_data changes only on a load. X_valid never drops without a handshake.
//   - X_ready may be asserted while X_valid=0. It has no effect.
//
// CONFIGURATION
//   STREAM_DEMUX_CNT_EN defined:
//     - Adds output ports a_count and b_count, each 8 bits.
//     - A port's counter increments on X_valid & X_ready and wraps 255 -> 0.
//     - Counters are cleared only by rst_n.
//   STREAM_DEMUX_CNT_EN undefined: the count ports and the counter logic do
//   not exist. Data behaviour is identical in both configurations.
//
// TESTING
//   1. Reset: assert rst_n=0 between clock edges -> all valids and datas read
//      0 immediately; in_ready=1 for both sel values.
//   2. Route: a_ready=b_ready=1; send 0x1234 with sel=0, then 0x9876 with
//      sel=1 on consecutive cycles -> a_data=0x1234 one cycle after its
//      accept, b_data=0x9876 one cycle later; in_ready stays 1 throughout.
//   3. Backpressure: a_ready=0; send 0xAAAA (sel=0), then 0x5555 (sel=0)
//      -> in_ready=0 while the second word is pending, a_data holds 0xAAAA.
//      Raise a_ready -> 0xAAAA drains and 0x5555 loads on the same edge;
//      a_valid stays 1.
//   4. Independence: port A stalled and full; send 0x0F0F with sel=1 and
//      b_ready=1 -> accepted immediately, b_data=0x0F0F, port A unchanged.
//   5. Reset mid-op: both ports FULL with ~ready; pulse rst_n low -> both
//      valids drop at once; the first word after release routes normally.
//   6. CNT_EN: hold a_ready=1 and stream 256 words to A -> a_count wraps to
//      0; b_count stays 0. Rebuild without the macro -> tests 1-5 still pass.

Source files
------------

// File: rtl/stream_demux16_if.sv
// Handshake bundle for stream_demux16: one input stream and two output ports.
// STREAM_DEMUX_CNT_EN adds the per-port 8-bit transfer counters.
interface stream_demux16_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sel;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
`ifdef STREAM_DEMUX_CNT_EN
    logic [7:0]       a_count;
    logic [7:0]       b_count;
`endif

    // Producer/consumer side (testbench or surrounding datapath)
    modport master (
        output in_valid, in_data, sel, a_ready, b_ready,
`ifdef STREAM_DEMUX_CNT_EN
        input  a_count, b_count,
`endif
        input  in_ready, a_valid, a_data, b_valid, b_data
    );

    // Demux side
    modport slave (
        input  in_valid, in_data, sel, a_ready, b_ready,
`ifdef STREAM_DEMUX_CNT_EN
        output a_count, b_count,
`endif
        output in_ready, a_valid, a_data, b_valid, b_data
    );
endinterface

// File: rtl/stream_demux16.sv
// Registered 1:2 stream demux with a one-entry holding register per output port.
// Optional STREAM_DEMUX_CNT_EN adds wrapping 8-bit handshake counters per port.
module stream_demux16 #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_demux16_if.slave bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } port_state_e;

    port_state_e      a_state_q, a_state_d;
    port_state_e      b_state_q, b_state_d;
    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;
    logic             accept, a_load, b_load, a_take, b_take;

    // in_ready depends only on the selected port's state and its consumer ready.
    assign bus.in_ready = bus.sel ? ((b_state_q == EMPTY) || bus.b_ready)
                                  : ((a_state_q == EMPTY) || bus.a_ready);
    assign accept = bus.in_valid & bus.in_ready;
    assign a_load = accept & ~bus.sel;
    assign b_load = accept &  bus.sel;
    assign a_take = (a_state_q == FULL) & bus.a_ready;
    assign b_take = (b_state_q == FULL) & bus.b_ready;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no latch is inferred.
        a_state_d = a_state_q;
        b_state_d = b_state_q;
        a_data_d  = a_data_q;
        b_data_d  = b_data_q;

        case (a_state_q)
            EMPTY: if (a_load) a_state_d = FULL;
            FULL:  if (a_take && !a_load) a_state_d = EMPTY;
        endcase
        case (b_state_q)
            EMPTY: if (b_load) b_state_d = FULL;
            FULL:  if (b_take && !b_load) b_state_d = EMPTY;
        endcase

        if (a_load) a_data_d = bus.in_data;
        if (b_load) b_data_d = bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst_n) begin
            a_state_q <= EMPTY;
            b_state_q <= EMPTY;
            a_data_q  <= '0;
            b_data_q  <= '0;
        end else begin
            a_state_q <= a_state_d;
            b_state_q <= b_state_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
        end
    end

    assign bus.a_valid = (a_state_q == FULL);
    assign bus.b_valid = (b_state_q == FULL);
    assign bus.a_data  = a_data_q;
    assign bus.b_data  = b_data_q;

`ifdef STREAM_DEMUX_CNT_EN
    logic [7:0] a_count_q, a_count_d;
    logic [7:0] b_count_q, b_count_d;

    assign a_count_d = a_count_q + 8'(a_take);
    assign b_count_d = b_count_q + 8'(b_take);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign bus.a_count = a_count_q;
    assign bus.b_count = b_count_q;
`endif
endmodule

// File: tb/tb_stream_demux16.sv
// Self-checking bench for stream_demux16: directed scenarios plus randomized
// traffic against a queue-based reference model; define STREAM_DEMUX_CNT_EN to cover counters.
module tb_stream_demux16;
    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    stream_demux16_if #(.WIDTH(16)) bus ();

    stream_demux16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each port is a queue holding at most one word.
    logic [15:0] mdl_a_q[$];
    logic [15:0] mdl_b_q[$];
    logic [15:0] mdl_a_data, mdl_b_data;
    int          mdl_a_cnt, mdl_b_cnt;

    function automatic logic mdl_ready(logic s);
        if (s) return (mdl_b_q.size() == 0) || bus.b_ready;
        return (mdl_a_q.size() == 0) || bus.a_ready;
    endfunction

    task automatic mdl_clear();
        mdl_a_q.delete();
        mdl_b_q.delete();
        mdl_a_data = '0;
        mdl_b_data = '0;
        mdl_a_cnt  = 0;
        mdl_b_cnt  = 0;
    endtask

    // Advance one clock; returns at posedge+1 with the model updated.
    task automatic tick();
        logic        acc, s, ar, br;
        logic [15:0] d;
        s   = bus.sel;
        d   = bus.in_data;
        ar  = bus.a_ready;
        br  = bus.b_ready;
        acc = bus.in_valid && mdl_ready(s);
        @(posedge clk);
        #1;
        if (ar && mdl_a_q.size() > 0) begin
            void'(mdl_a_q.pop_front());
            mdl_a_cnt = (mdl_a_cnt + 1) % 256;
        end
        if (br && mdl_b_q.size() > 0) begin
            void'(mdl_b_q.pop_front());
            mdl_b_cnt = (mdl_b_cnt + 1) % 256;
        end
        if (acc) begin
            if (s) begin
                mdl_b_q.push_back(d);
                mdl_b_data = d;
            end else begin
                mdl_a_q.push_back(d);
                mdl_a_data = d;
            end
        end
    endtask

    task automatic pulse_reset();
        #3 rst_n = 1'b0;
        mdl_clear();
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1;
        bus.sel      = 1'b0;
        bus.in_data  = 16'hBEEF;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        pulse_reset();
        checks++; if (bus.a_valid !== 1'b0) $display("FAIL reset_a_valid: got %b want 0", bus.a_valid); else passed++;
        checks++; if (bus.b_valid !== 1'b0) $display("FAIL reset_b_valid: got %b want 0", bus.b_valid); else passed++;
        checks++; if (bus.a_data !== 16'h0) $display("FAIL reset_a_data: got %h want 0000", bus.a_data); else passed++;
        checks++; if (bus.b_data !== 16'h0) $display("FAIL reset_b_data: got %h want 0000", bus.b_data); else passed++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready_sel0: got %b want 1", bus.in_ready); else passed++;
        bus.sel = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready_sel1: got %b want 1", bus.in_ready); else passed++;
`ifdef STREAM_DEMUX_CNT_EN
        checks++; if (bus.a_count !== 8'd0) $display("FAIL reset_a_count: got %0d want 0", bus.a_count); else passed++;
        checks++; if (bus.b_count !== 8'd0) $display("FAIL reset_b_count: got %0d want 0", bus.b_count); else passed++;
`endif
        release_reset();
    endtask

    task automatic test_route();
        bus.a_ready  = 1'b1;
        bus.b_ready  = 1'b1;
        bus.in_valid = 1'b1;
        bus.sel      = 1'b0;
        bus.in_data  = 16'h1234;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL route_ready0: got %b want 1", bus.in_ready); else passed++;
        tick();
        checks++; if (bus.a_valid !== 1'b1 || bus.a_data !== 16'h1234) $display("FAIL route_a: got %b/%h want 1/1234", bus.a_valid, bus.a_data); else passed++;
        bus.sel     = 1'b1;
        bus.in_data = 16'h9876;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL route_ready1: got %b want 1", bus.in_ready); else passed++;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.b_valid !== 1'b1 || bus.b_data !== 16'h9876) $display("FAIL route_b: got %b/%h want 1/9876", bus.b_valid, bus.b_data); else passed++;
        checks++; if (bus.a_valid !== 1'b0 || bus.a_data !== 16'h1234) $display("FAIL route_a_drained: got %b/%h want 0/1234", bus.a_valid, bus.a_data); else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        bus.a_ready  = 1'b0;
        bus.in_valid = 1'b1;
        bus.sel      = 1'b0;
        bus.in_data  = 16'hAAAA;
        tick();
        bus.in_data = 16'h5555;
        #1;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_stall_ready: got %b want 0", bus.in_ready); else passed++;
        tick();
        checks++; if (bus.a_valid !== 1'b1 || bus.a_data !== 16'hAAAA) $display("FAIL bp_hold: got %b/%h want 1/aaaa", bus.a_valid, bus.a_data); else passed++;
        bus.a_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); else passed++;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.a_valid !== 1'b1 || bus.a_data !== 16'h5555) $display("FAIL bp_refill: got %b/%h want 1/5555", bus.a_valid, bus.a_data); else passed++;
        tick();
        checks++; if (bus.a_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", bus.a_valid); else passed++;
    endtask

    task automatic test_independence();
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b1;
        bus.in_valid = 1'b1;
        bus.sel      = 1'b0;
        bus.in_data  = 16'h1111;
        tick();
        bus.sel     = 1'b1;
        bus.in_data = 16'h0F0F;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL indep_ready: got %b want 1", bus.in_ready); else passed++;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.b_valid !== 1'b1 || bus.b_data !== 16'h0F0F) $display("FAIL indep_b: got %b/%h want 1/0f0f", bus.b_valid, bus.b_data); else passed++;
        checks++; if (bus.a_valid !== 1'b1 || bus.a_data !== 16'h1111) $display("FAIL indep_a: got %b/%h want 1/1111", bus.a_valid, bus.a_data); else passed++;
    endtask

    task automatic test_reset_midop();
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
        bus.in_valid = 1'b1;
        bus.sel      = 1'b1;
        bus.in_data  = 16'h2222;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b1) $display("FAIL midop_full: got %b%b want 11", bus.a_valid, bus.b_valid); else passed++;
        pulse_reset();
        checks++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) $display("FAIL midop_async_clear: got %b%b want 00", bus.a_valid, bus.b_valid); else passed++;
        release_reset();
        bus.a_ready  = 1'b1;
        bus.in_valid = 1'b1;
        bus.sel      = 1'b0;
        bus.in_data  = 16'h3333;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.a_valid !== 1'b1 || bus.a_data !== 16'h3333) $display("FAIL midop_after: got %b/%h want 1/3333", bus.a_valid, bus.a_data); else passed++;
        checks++; if (bus.b_valid !== 1'b0 || bus.b_data !== 16'h0) $display("FAIL midop_b_idle: got %b/%h want 0/0000", bus.b_valid, bus.b_data); else passed++;
        tick();
    endtask

    task automatic test_random();
        logic acc;
        logic hold;
        int   errs;
        errs = 0;
        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.sel      = 1'($urandom_range(0, 1));
                bus.in_data  = 16'($urandom);
            end
            bus.a_ready = ($urandom_range(0, 9) < 6);
            bus.b_ready = ($urandom_range(0, 9) < 6);
            #1;
            acc = bus.in_valid && mdl_ready(bus.sel);
            checks++; if (bus.in_ready !== mdl_ready(bus.sel)) begin $display("FAIL rnd_in_ready @%0d: got %b want %b", i, bus.in_ready, mdl_ready(bus.sel)); errs++; end else passed++;
            tick();
            hold = bus.in_valid && !acc;
            checks++; if (bus.a_valid !== (mdl_a_q.size() != 0) || bus.a_data !== mdl_a_data) begin $display("FAIL rnd_port_a @%0d: got %b/%h want %b/%h", i, bus.a_valid, bus.a_data, mdl_a_q.size() != 0, mdl_a_data); errs++; end else passed++;
            checks++; if (bus.b_valid !== (mdl_b_q.size() != 0) || bus.b_data !== mdl_b_data) begin $display("FAIL rnd_port_b @%0d: got %b/%h want %b/%h", i, bus.b_valid, bus.b_data, mdl_b_q.size() != 0, mdl_b_data); errs++; end else passed++;
`ifdef STREAM_DEMUX_CNT_EN
            checks++; if (bus.a_count !== 8'(mdl_a_cnt) || bus.b_count !== 8'(mdl_b_cnt)) begin $display("FAIL rnd_counts @%0d: got %0d/%0d want %0d/%0d", i, bus.a_count, bus.b_count, mdl_a_cnt, mdl_b_cnt); errs++; end else passed++;
`endif
            if (errs > 10) break;
        end
        bus.in_valid = 1'b0;
        bus.a_ready  = 1'b1;
        bus.b_ready  = 1'b1;
        tick();
        tick();
    endtask

`ifdef STREAM_DEMUX_CNT_EN
    task automatic test_count_wrap();
        bus.in_valid = 1'b0;
        pulse_reset();
        release_reset();
        bus.a_ready  = 1'b1;
        bus.b_ready  = 1'b0;
        bus.in_valid = 1'b1;
        bus.sel      = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus.in_data = 16'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.a_count !== 8'd255) $display("FAIL cnt_a_255: got %0d want 255", bus.a_count); else passed++;
        tick();
        checks++; if (bus.a_count !== 8'd0) $display("FAIL cnt_a_wrap: got %0d want 0", bus.a_count); else passed++;
        checks++; if (bus.b_count !== 8'd0) $display("FAIL cnt_b_idle: got %0d want 0", bus.b_count); else passed++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks       = 0;
        passed       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.sel      = 1'b0;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
        mdl_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;

        test_reset();
        test_route();
        test_backpressure();
        test_independence();
        test_reset_midop();
        test_random();
`ifdef STREAM_DEMUX_CNT_EN
        test_count_wrap();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
